// File: rtl/gate_vector_checker.sv
// Self-test stage for the two-input gate block: walks {a,b} through 00..11,
// holds each vector HOLD_CYCLES cycles, and scores the six gate outputs.
module gate_vector_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_in,
  input  logic             or_in,
  input  logic             xor_in,
  input  logic             xnor_in,
  input  logic             nand_in,
  input  logic             notb_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       fail_q, fail_d;

  logic [5:0]       exp_v, obs_v, diff_v;
  logic [2:0]       n_mis;
  logic [ERR_W+2:0] sum;
  logic [ERR_W-1:0] err_sat;
  logic             sample;

  // idx_q doubles as the registered stimulus; it is zero outside RUN
  assign a = idx_q[1];
  assign b = idx_q[0];

  always_comb begin
    exp_v  = {~b, ~(a & b), ~(a ^ b), a ^ b, a | b, a & b};
    obs_v  = {notb_in, nand_in, xnor_in, xor_in, or_in, and_in};
    diff_v = exp_v ^ obs_v;
    n_mis  = '0;
    for (int i = 0; i < 6; i++) n_mis = n_mis + 3'(diff_v[i]);
    sum     = {3'b000, err_q} + (ERR_W+3)'(n_mis);
    err_sat = (sum > (ERR_W+3)'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
    sample  = (state_q == S_RUN) && (hold_q == HW'(HOLD_CYCLES - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          hold_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end
      S_RUN: begin
        hold_d = hold_q + 1'b1;
        if (sample) begin
          err_d  = err_sat;
          if (n_mis != 3'd0) fail_d[idx_q] = 1'b1;
          hold_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_DONE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
